// File: rtl/sample1_pkg.sv
// Shared definitions for the sample1 register slice: default width and the
// occupancy state used by assertions and debug.
package sample1_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Occupancy is fully described by the two valid flags; no separate state register.
  function automatic state_e state_of(logic main_valid, logic skid_valid);
    if (skid_valid) return FULL;
    if (main_valid) return ONE;
    return EMPTY;
  endfunction

endpackage

// File: rtl/sample1.sv
// Single-stage valid/ready register slice with a one-word skid buffer.
// Data, valid and the upstream ready are all registered.
module sample1
  import sample1_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  output logic         out_ready,
  output logic [N-1:0] out_data
);

  logic [N-1:0] skid_data;
  logic         skid_valid;
  logic         accept;
  logic         drain;
  state_e       state;

  assign accept = in_valid && out_ready;
  assign drain  = out_valid && in_ready;
  assign state  = state_of(out_valid, skid_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ready  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          // out_ready is low only on the first cycle after reset, so no accept then.
          out_ready <= 1'b1;
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            out_data <= in_data;
          end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            out_ready  <= 1'b0;
          end else if (drain) begin
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
            out_ready  <= 1'b1;
          end
        end
        default: begin
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  a_full_not_ready : assert property (@(posedge clk) disable iff (!rst_n)
    (state == FULL) |-> !out_ready);

  a_skid_implies_main : assert property (@(posedge clk) disable iff (!rst_n)
    skid_valid |-> out_valid);

endmodule

// File: tb/tb_sample1.sv
// Self-checking bench for sample1: directed scenarios plus a randomized run,
// with expected words tracked in a FIFO scoreboard.
module tb_sample1;

  localparam int unsigned N = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] sb_q[$];
  logic         dr;
  logic [N-1:0] dr_data;

  sample1 #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample handshakes for the coming edge, record accepted words, then advance
  // to 1 time unit past the edge. Comparisons are done by the callers.
  task automatic tick();
    dr      = out_valid && in_ready;
    dr_data = out_data;
    if (in_valid && out_ready) sb_q.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_ready = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_out_data got=%h exp=0", out_data);
    end
    checks++;
    if (out_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_ready got=%b exp=0", out_ready);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    checks++;
    if (out_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", out_ready);
    end
  endtask

  task automatic test_pass_through();
    logic [N-1:0] words[2];
    logic [N-1:0] exp;
    words[0] = 32'h0123_4567;
    words[1] = 32'h7654_3210;
    in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = (i < 2);
      in_data  = (i < 2) ? words[i] : '0;
      tick();
      if (dr) begin
        exp = sb_q.pop_front();
        checks++;
        if (dr_data !== exp) begin
          failures++;
          $display("FAIL pass_drain got=%h exp=%h", dr_data, exp);
        end
      end
      if (i < 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== words[i]) begin
          failures++;
          $display("FAIL pass_out[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, words[i]);
        end
      end
      checks++;
      if (out_ready !== 1'b1) begin
        failures++;
        $display("FAIL pass_ready[%0d] got=%b exp=1", i, out_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall_skid();
    logic [N-1:0] exp;
    in_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hABCD_EF00;
    tick();
    in_data  = 32'h1111_1111;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_ready !== 1'b0 || out_data !== 32'hABCD_EF00) begin
      failures++;
      $display("FAIL stall_full got=%b/%h exp=0/abcdef00", out_ready, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hABCD_EF00) begin
      failures++;
      $display("FAIL stall_hold got=%b/%h exp=1/abcdef00", out_valid, out_data);
    end
    in_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (!dr || sb_q.size() == 0) begin
        failures++;
        $display("FAIL stall_drain[%0d] got=no_drain exp=drain", i);
      end else begin
        exp = sb_q.pop_front();
        if (dr_data !== exp) begin
          failures++;
          $display("FAIL stall_drain[%0d] got=%h exp=%h", i, dr_data, exp);
        end
      end
    end
    checks++;
    if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_end got=rdy%b/vld%b exp=1/0", out_ready, out_valid);
    end
  endtask

  task automatic test_bubble();
    logic [N-1:0] exp;
    in_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    in_data  = 32'h5555_5555;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL bubble_first got=%b/%h exp=1/deadbeef", out_valid, out_data);
    end
    tick();
    if (dr) begin
      exp = sb_q.pop_front();
      checks++;
      if (dr_data !== exp) begin
        failures++;
        $display("FAIL bubble_drain got=%h exp=%h", dr_data, exp);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bubble_gap got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp;
    logic         stalled;
    logic [N-1:0] held;
    int           bad_order = 0;
    int           bad_hold  = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_ready = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      stalled  = out_valid && !in_ready;
      held     = out_data;
      tick();
      if (dr) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL rand_dup cycle=%0d got=%h exp=no_word", i, dr_data);
        end else begin
          exp = sb_q.pop_front();
          if (dr_data !== exp && bad_order++ < 5) begin
            failures++;
            $display("FAIL rand_order cycle=%0d got=%h exp=%h", i, dr_data, exp);
          end
        end
      end
      if (stalled) begin
        checks++;
        if ((out_valid !== 1'b1 || out_data !== held) && bad_hold++ < 5) begin
          failures++;
          $display("FAIL rand_hold cycle=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, held);
        end
      end
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dr && sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        checks++;
        if (dr_data !== exp) begin
          failures++;
          $display("FAIL rand_flush got=%h exp=%h", dr_data, exp);
        end
      end
    end
    checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_loss got=left%0d/vld%b exp=0/0", sb_q.size(), out_valid);
    end
  endtask

  task automatic test_async_reset_full();
    in_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hCAFE_0001;
    tick();
    in_data  = 32'hCAFE_0002;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_prefill got=rdy%b/vld%b exp=0/1", out_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ready !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL areset_drop got=%b/%b/%h exp=0/0/0", out_valid, out_ready, out_data);
    end
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || dr) begin
        failures++;
        $display("FAIL areset_stale[%0d] got=vld%b/%h exp=0", i, out_valid, out_data);
      end
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_ready = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    test_reset();
    test_pass_through();
    test_stall_skid();
    test_bubble();
    test_random();
    test_async_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample1.md
Name: sample1

Overview:
- Single-stage valid/ready register slice (skid buffer) carrying an N-bit data word between a producer and a consumer.
- It registers data, valid and the upstream ready, so no combinational path crosses the block.
- It sustains one transfer per cycle with one cycle of latency.
- It sits on streaming datapaths between pipeline stages to break timing paths.

Parameters:
- N, 32, data word width in bits (N >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low. Asserting it clears state immediately; release is sampled on clk.
- in_valid  input  1  producer asserts when in_data is valid.
- in_ready  input  1  consumer ready; the consumer takes out_data when out_valid && in_ready.
- in_data  input  N  producer data word.
- out_valid  output  N/A (1)  out_data holds a valid word for the consumer.
- out_ready  output  1  block can accept a word from the producer this cycle; registered.
- out_data  output  N  data word presented to the consumer; registered.

Behaviour:
- Handshake definitions:
  - accept = in_valid && out_ready.
  - drain = out_valid && in_ready.
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_ready=0.
  - Skid register cleared; skid_valid=0.
- out_ready rises to 1 on the first rising clk edge after rst_n is released.
- Storage:
  - Main register drives out_data/out_valid.
  - One skid register (N bits plus skid_valid) absorbs the word accepted on a cycle when the consumer stalls.
- out_ready is registered and equals !skid_valid from the previous edge.
- State EMPTY (out_valid=0, skid_valid=0):
  - On accept: main <= in_data, out_valid <= 1, go to ONE.
- State ONE (out_valid=1, skid_valid=0):
  - accept && drain: main <= in_data, stay in ONE.
  - accept && !drain: skid <= in_data, skid_valid <= 1, out_ready <= 0, go to FULL.
  - !accept && drain: out_valid <= 0, go to EMPTY.
  - Neither: hold.
- State FULL (out_valid=1, skid_valid=1, out_ready=0):
  - accept is impossible in this state.
  - On drain: main <= skid, skid_valid <= 0, out_ready <= 1, go to ONE.
  - Otherwise hold.
- Latency: a word accepted at edge k appears on out_data with out_valid=1 after edge k, provided the block was EMPTY or draining.
- Throughput: one word per cycle when in_ready is held high.
- Ordering is strictly FIFO; no word is dropped or duplicated.
- While out_valid && !in_ready, out_data and out_valid stay stable.
- in_data is ignored whenever accept=0.
- in_ready and in_valid may toggle freely with no protocol violation.
- in_valid deasserting with no prior accept loses nothing.
- Reset mid-transfer discards both stored words at once. out_valid drops asynchronously.
- Data values pass through bit-exact; there is no arithmetic.

Decomposition:
- Package sample1_pkg holds:
  - the default-width constant (32);
  - a state enum {EMPTY, ONE, FULL} used for assertions and debug. State is derivable from out_valid and skid_valid.
- No sub-module; a flat single module is natural.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_data=0, out_ready=0. One edge after release -> out_ready=1.
- Pass-through: in_ready=1, in_valid=1, in_data=32'h01234567 then 32'h76543210 on consecutive edges -> out_data shows 01234567 then 76543210 one cycle later each; out_ready stays 1.
- Stall/skid: in_ready=0, send 32'hABCDEF00 then 32'h11111111 -> out_data=ABCDEF00 held, out_ready=0 after the second accept. Raise in_ready -> ABCDEF00 then 11111111 drained in order; out_ready returns to 1.
- Bubble: single word 32'hDEADBEEF with in_ready=1, then in_valid=0 -> out_valid high for exactly one cycle, then 0.
- Random: random in_valid/in_ready over 1000 cycles against a reference queue -> all words delivered in order with no loss or duplicates; out_data stable while out_valid && !in_ready.
- Async reset in FULL: assert rst_n mid-cycle -> out_valid drops immediately; no stale word appears after release.
